// File: rtl/gc_input_conditioner_if.sv
// Controller-to-game bus: raw controller levels in, frame-stable levels and pulses out.
interface gc_input_conditioner_if;
    logic        frame_tick;
    logic [11:0] buttons;
    logic [7:0]  JOY_X;
    logic [7:0]  JOY_Y;
    logic [11:0] held;
    logic [11:0] pressed;
    logic [11:0] released;
    logic [3:0]  nav;
    logic [3:0]  nav_pulse;

    // Producer of raw controller state and frame timing
    modport master (
        output frame_tick, buttons, JOY_X, JOY_Y,
        input  held, pressed, released, nav, nav_pulse
    );

    // Input conditioner
    modport slave (
        input  frame_tick, buttons, JOY_X, JOY_Y,
        output held, pressed, released, nav, nav_pulse
    );
endinterface

// File: rtl/gc_input_conditioner.sv
// Frame-synchronous controller conditioning: button edges plus four-way
// navigation with deadzone, opposing-direction cancel and menu auto-repeat.
module gc_input_conditioner #(
    parameter int unsigned CENTER       = 128,
    parameter int unsigned DEADZONE     = 40,
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    gc_input_conditioner_if.slave  bus
);
    localparam int unsigned NDIR    = 4;
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Thresholds kept signed and wider than the axis so a large deadzone cannot wrap
    localparam logic signed [9:0] HI_TH = 10'(int'(CENTER) + int'(DEADZONE));
    localparam logic signed [9:0] LO_TH = 10'(int'(CENTER) - int'(DEADZONE));

    // Direction bit positions within nav: {left,right,down,up}
    localparam int unsigned UP    = 0;
    localparam int unsigned DOWN  = 1;
    localparam int unsigned RIGHT = 2;
    localparam int unsigned LEFT  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } dir_state_t;

    logic signed [9:0] joy_x_s;
    logic signed [9:0] joy_y_s;
    logic [NDIR-1:0]   dir_raw_c;
    logic [NDIR-1:0]   dir_c;
    logic [NDIR-1:0]   pulse_c;

    dir_state_t        state_q [NDIR];
    dir_state_t        state_d [NDIR];
    logic [CNT_W-1:0]  cnt_q   [NDIR];
    logic [CNT_W-1:0]  cnt_d   [NDIR];

    logic [11:0]       held_q;
    logic [11:0]       pressed_q;
    logic [11:0]       released_q;
    logic [NDIR-1:0]   nav_q;
    logic [NDIR-1:0]   nav_pulse_q;

    assign joy_x_s = $signed({2'b00, bus.JOY_X});
    assign joy_y_s = $signed({2'b00, bus.JOY_Y});

    // Raw directions from D-pad or stick beyond the deadzone, then cancel opposing pairs
    always_comb begin
        dir_raw_c        = '0;
        dir_raw_c[UP]    = bus.buttons[8]  | (joy_y_s > HI_TH);
        dir_raw_c[DOWN]  = bus.buttons[9]  | (joy_y_s < LO_TH);
        dir_raw_c[RIGHT] = bus.buttons[10] | (joy_x_s > HI_TH);
        dir_raw_c[LEFT]  = bus.buttons[11] | (joy_x_s < LO_TH);
        dir_c            = dir_raw_c;
        if (dir_raw_c[UP] && dir_raw_c[DOWN]) begin
            dir_c[UP]   = 1'b0;
            dir_c[DOWN] = 1'b0;
        end
        if (dir_raw_c[LEFT] && dir_raw_c[RIGHT]) begin
            dir_c[LEFT]  = 1'b0;
            dir_c[RIGHT] = 1'b0;
        end
    end

    // Auto-repeat FSM next state; only advances on frame update edges
    always_comb begin
        pulse_c = '0;
        for (int i = 0; i < NDIR; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (bus.frame_tick) begin
                case (state_q[i])
                    IDLE: begin
                        if (dir_c[i]) begin
                            pulse_c[i] = 1'b1;
                            cnt_d[i]   = CNT_W'(1);
                            state_d[i] = DELAY;
                        end
                    end
                    DELAY: begin
                        if (!dir_c[i]) begin
                            cnt_d[i]   = '0;
                            state_d[i] = IDLE;
                        end else if (cnt_q[i] == CNT_W'(REPEAT_DELAY)) begin
                            pulse_c[i] = 1'b1;
                            cnt_d[i]   = CNT_W'(1);
                            state_d[i] = REPEAT;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!dir_c[i]) begin
                            cnt_d[i]   = '0;
                            state_d[i] = IDLE;
                        end else if (cnt_q[i] == CNT_W'(REPEAT_RATE)) begin
                            pulse_c[i] = 1'b1;
                            cnt_d[i]   = CNT_W'(1);
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_d[i]   = '0;
                        state_d[i] = IDLE;
                    end
                endcase
            end
        end
    end

    // Auto-repeat FSM state and frame counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NDIR; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NDIR; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Frame-sampled levels hold between ticks; edge and repeat pulses last one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_q      <= '0;
            pressed_q   <= '0;
            released_q  <= '0;
            nav_q       <= '0;
            nav_pulse_q <= '0;
        end else if (bus.frame_tick) begin
            held_q      <= bus.buttons;
            pressed_q   <= bus.buttons & ~held_q;
            released_q  <= ~bus.buttons & held_q;
            nav_q       <= dir_c;
            nav_pulse_q <= pulse_c;
        end else begin
            pressed_q   <= '0;
            released_q  <= '0;
            nav_pulse_q <= '0;
        end
    end

    assign bus.held      = held_q;
    assign bus.pressed   = pressed_q;
    assign bus.released  = released_q;
    assign bus.nav       = nav_q;
    assign bus.nav_pulse = nav_pulse_q;

endmodule

// File: doc/gc_input_conditioner.md
Name: gc_input_conditioner

Overview:
- Sits between the gamecube controller decoder and pixel_generation.
- Samples raw controller state once per video frame, so game logic sees values that are stable for the whole frame.
- Produces per-button press/release pulses.
- Merges D-pad and main joystick (with deadzone) into four navigation directions, each with menu-style auto-repeat.

Parameters:
CENTER, 128, joystick rest value (unsigned 8-bit axis)
DEADZONE, 40, axis offset from CENTER at or below which the stick counts as neutral
REPEAT_DELAY, 20, frames a direction is held before the first auto-repeat pulse
REPEAT_RATE, 6, frames between subsequent auto-repeat pulses

Ports:
clk  input  1  system clock (100 MHz)
reset_n  input  1  asynchronous, active-low reset
frame_tick  input  1  one-cycle pulse once per frame (start of vertical blank)
buttons  input  12  raw levels {D_LEFT,D_RIGHT,D_DOWN,D_UP,Z,R,L,start_pause,Y,X,B,A}, bit0=A
JOY_X  input  8  raw main stick X, larger = right
JOY_Y  input  8  raw main stick Y, larger = up
held  output  12  frame-sampled button levels, same bit order
pressed  output  12  one-cycle pulse per bit on a 0->1 transition between frames
released  output  12  one-cycle pulse per bit on a 1->0 transition between frames
nav  output  4  frame-sampled direction levels {left,right,down,up}
nav_pulse  output  4  one-cycle pulse per direction: initial press plus auto-repeats

Behaviour:
- Reset: all outputs 0, all internal sample registers 0, every direction FSM in IDLE, all counters 0. The first frame after reset therefore treats any held button as a new press.
- All registers update only on the clk edge where frame_tick=1. On every other edge, held and nav keep their values, and pressed, released and nav_pulse are 0.
- Update edge, buttons:
  - held <= buttons.
  - pressed <= buttons & ~held.
  - released <= ~buttons & held.
  - These values are visible in the cycle after frame_tick and last exactly one cycle.
- Direction raw terms (unsigned compare, computed in 9 bits so there is no wrap):
  - up_raw = D_UP | (JOY_Y > CENTER+DEADZONE)
  - down_raw = D_DOWN | (JOY_Y < CENTER-DEADZONE)
  - right_raw = D_RIGHT | (JOY_X > CENTER+DEADZONE)
  - left_raw = D_LEFT | (JOY_X < CENTER-DEADZONE)
  - Values exactly at CENTER±DEADZONE are neutral.
- Opposing cancel: if up_raw&down_raw, both are forced to 0; likewise left&right. Diagonals (e.g. up+right) are allowed.
- nav <= cancelled direction levels on the update edge.
- Per-direction FSM, evaluated only on update edges, with a frame counter of ceil(log2(max(REPEAT_DELAY,REPEAT_RATE)+1)) bits:
  - IDLE: dir=1 -> pulse, cnt=1, go DELAY. dir=0 -> stay.
  - DELAY: dir=0 -> IDLE, cnt=0. cnt==REPEAT_DELAY -> pulse, cnt=1, go REPEAT. Otherwise cnt++.
  - REPEAT: dir=0 -> IDLE, cnt=0. cnt==REPEAT_RATE -> pulse, cnt=1, stay. Otherwise cnt++.
- Repeat timing: first pulse at frame N; first repeat at frame N+REPEAT_DELAY; further repeats every REPEAT_RATE frames.
- Release and re-press in consecutive frames: the release frame returns to IDLE, and the re-press frame pulses immediately.
- frame_tick asserted on consecutive cycles: each cycle is a separate update, with no special case.
- reset_n asserted mid-frame: immediately clears all state and outputs, and pulses stop in the same cycle.
- Latency: input change to held/nav/pulse is at most one frame plus one clk.

Test Plan:
- Reset with A=1, then frame_tick: held[0]=1 and pressed[0]=1 for exactly one cycle after the tick. The next tick with A still 1 gives pressed[0]=0.
- A released before frame k: released[0]=1 for one cycle after tick k; held[0]=0; pressed stays 0.
- JOY_X=168 then 169 (CENTER 128, DEADZONE 40): nav[2]=0 at 168; nav[2]=1 and nav_pulse[2] fires at 169. JOY_X=87 gives nav[3]=1; JOY_X=88 gives neutral.
- D_UP held 40 frames (DELAY 20, RATE 6): nav_pulse[0] fires at frames 0, 20, 26, 32, 38, i.e. exactly 5 pulses, each one cycle wide.
- D_UP=1 with JOY_Y=0: up and down cancel, so nav[1:0]=0 and no pulses. Adding D_RIGHT gives only nav[2] active.
- Hold D_LEFT 25 frames, pulse reset_n low mid-frame for 3 cycles: all outputs 0 immediately. The next tick after release re-emits the initial nav_pulse[3]; no repeat occurs until 20 frames later.
